// File: rtl/prng_sampler.sv
// prng_sampler: packs data_in[TAP] samples into OUT_W-bit words in a DEPTH-word FIFO; a word is visible the cycle after its last bit, and a full FIFO with no pop drops the word.
// Define PRNG_SAMPLER_VON_NEUMANN_EN to debias raw samples in pairs before they reach the assembler.
module prng_sampler #(
   parameter int N     = 32,
   parameter int TAP   = 16,
   parameter int OUT_W = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic [N-1:0]             data_in,
   input  logic                     out_ready,
   output logic [OUT_W-1:0]         out_data,
   output logic                     out_valid,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [7:0]               drop_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(OUT_W - 1);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   logic [OUT_W-1:0] asm_q, asm_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [OUT_W-1:0] mem_q [DEPTH];
   logic [OUT_W-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [7:0]       drop_q, drop_d;
   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_data_q, out_data_d;

   logic             sample;
   logic             bit_vld;
   logic             bit_val;
   logic             push;
   logic             pop;
   logic             full;
   logic             do_push;
   logic [OUT_W-1:0] word;
   logic             unused_bits;

   assign sample      = data_in[TAP];
   assign unused_bits = ^{data_in, asm_q[OUT_W-1]};

`ifdef PRNG_SAMPLER_VON_NEUMANN_EN
   logic pair_vld_q, pair_vld_d;
   logic pair_bit_q, pair_bit_d;

   // A differing pair yields its first sample; equal pairs are discarded.
   always_comb begin
      pair_vld_d = pair_vld_q;
      pair_bit_d = pair_bit_q;
      bit_vld    = 1'b0;
      bit_val    = pair_bit_q;
      if (enable) begin
         if (!pair_vld_q) begin
            pair_vld_d = 1'b1;
            pair_bit_d = sample;
         end else begin
            pair_vld_d = 1'b0;
            pair_bit_d = 1'b0;
            bit_vld    = (pair_bit_q != sample);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pair_vld_q <= 1'b0;
         pair_bit_q <= 1'b0;
      end else begin
         pair_vld_q <= pair_vld_d;
         pair_bit_q <= pair_bit_d;
      end
   end
`else
   always_comb begin
      bit_vld = enable;
      bit_val = sample;
   end
`endif

   always_comb begin
      word      = {asm_q[OUT_W-2:0], bit_val};
      asm_d     = asm_q;
      bit_cnt_d = bit_cnt_q;
      push      = 1'b0;
      if (bit_vld) begin
         asm_d = word;
         if (bit_cnt_q == LAST_BIT) begin
            push      = 1'b1;
            bit_cnt_d = '0;
         end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
         end
      end
   end

   // A same-edge pop frees the slot, so a full FIFO still accepts the push.
   always_comb begin
      full     = (count_q == FULL_CNT);
      pop      = out_valid_q & out_ready;
      do_push  = push & (~full | pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      drop_d   = drop_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = word;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !do_push) begin
         count_d = count_q - 1'b1;
      end
      if (push && !do_push && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 1'b1;
      end
      out_valid_d = (count_d != '0);
      out_data_d  = out_valid_d ? mem_d[rd_ptr_d] : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         asm_q       <= '0;
         bit_cnt_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         drop_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         asm_q       <= asm_d;
         bit_cnt_q   <= bit_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         drop_q      <= drop_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         mem_q       <= mem_d;
      end
   end

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign fifo_count = count_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_prng_sampler.sv
// Bench for prng_sampler (N=32, TAP=16, OUT_W=8, DEPTH=4): vector table, directed corner sequences and random traffic vs a queue model.
`timescale 1ns/1ps
module tb_prng_sampler;
   localparam int N = 32, TAP = 16, OUT_W = 8, DEPTH = 4;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         enable = 1'b0;
   logic         out_ready = 1'b0;
   logic [N-1:0] data_in = '0;
   logic [7:0]   out_data;
   logic         out_valid;
   logic [2:0]   fifo_count;
   logic [7:0]   drop_count;

   prng_sampler #(.N(N), .TAP(TAP), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .data_in(data_in),
      .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
      .fifo_count(fifo_count), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: raw samples -> accepted bit list -> words -> bounded queue.
   logic [7:0] m_fifo[$];
   bit         m_acc[$];
   int         m_drop;
   bit         m_pend;
   bit         m_pbit;

   typedef struct {
      bit         en;
      bit         s;
      bit         rdy;
      bit         vld;
      logic [7:0] dat;
      int         cnt;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_fifo.delete();
      m_acc.delete();
      m_drop = 0;
      m_pend = 1'b0;
      m_pbit = 1'b0;
   endtask

   task automatic model_edge(input bit en, input bit s, input bit rdy);
      bit         b_vld;
      bit         b;
      bit         pop;
      logic [7:0] w;
      b_vld = 1'b0;
      b     = 1'b0;
      pop   = rdy && (m_fifo.size() > 0);
      if (en) begin
`ifdef PRNG_SAMPLER_VON_NEUMANN_EN
         if (!m_pend) begin
            m_pend = 1'b1;
            m_pbit = s;
         end else begin
            m_pend = 1'b0;
            if (m_pbit != s) begin
               b_vld = 1'b1;
               b     = m_pbit;
            end
         end
`else
         b_vld = 1'b1;
         b     = s;
`endif
      end
      if (pop) void'(m_fifo.pop_front());
      if (b_vld) begin
         m_acc.push_back(b);
         if (m_acc.size() == OUT_W) begin
            w = '0;
            foreach (m_acc[i]) w = {w[6:0], m_acc[i]};
            m_acc.delete();
            if (m_fifo.size() < DEPTH) m_fifo.push_back(w);
            else if (m_drop < 255) m_drop++;
         end
      end
   endtask

   task automatic model_check(input string tag);
      chk({tag, "_vld"}, 32'(out_valid), 32'(m_fifo.size() > 0));
      chk({tag, "_cnt"}, 32'(fifo_count), 32'(m_fifo.size()));
      chk({tag, "_drop"}, 32'(drop_count), 32'(m_drop));
      if (m_fifo.size() > 0) chk({tag, "_dat"}, 32'(out_data), 32'(m_fifo[0]));
   endtask

   task automatic step(input bit en, input bit s, input bit rdy);
      enable    = en;
      out_ready = rdy;
      data_in   = $urandom;
      data_in[TAP] = s;
      @(posedge clk);
      model_edge(en, s, rdy);
      #1;
      model_check("model");
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)), rdy);
   endtask

   // One accepted bit; in debias mode it is sent as the pair (b, ~b).
   task automatic send_bit(input bit b, input bit rdy);
`ifdef PRNG_SAMPLER_VON_NEUMANN_EN
      step(1'b1, b, 1'b0);
      step(1'b1, ~b, rdy);
`else
      step(1'b1, b, rdy);
`endif
   endtask

   task automatic send_word(input logic [7:0] w, input bit rdy_last);
      for (int i = 7; i >= 0; i--) send_bit(w[i], (i == 0) ? rdy_last : 1'b0);
   endtask

   // Asserts reset midway between edges and checks outputs clear immediately.
   task automatic do_reset();
      #3;
      reset_n = 1'b0;
      #1;
      chk("rst_vld", 32'(out_valid), 32'd0);
      chk("rst_dat", 32'(out_data), 32'd0);
      chk("rst_cnt", 32'(fifo_count), 32'd0);
      chk("rst_drop", 32'(drop_count), 32'd0);
      model_reset();
      #2;
      reset_n = 1'b1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      logic [19:0] raw;
      logic [7:0]  fin;
      int          len;
      logic [7:0]  w;
      logic [7:0]  exp_q[$];

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Vector table: one word assembled with out_ready high, then an empty pop.
`ifdef PRNG_SAMPLER_VON_NEUMANN_EN
      raw = 20'b01_10_00_11_10_01_10_10_01_10;
      fin = 8'h6D;
      len = 20;
`else
      raw = {12'h000, 8'b1011_0010};
      fin = 8'hB2;
      len = 8;
`endif
      for (int i = 0; i < len; i++)
         tbl.push_back('{en: 1'b1, s: raw[len-1-i], rdy: 1'b1, vld: (i == len-1),
                         dat: fin, cnt: (i == len-1) ? 1 : 0});
      tbl.push_back('{en: 1'b0, s: 1'b0, rdy: 1'b1, vld: 1'b0, dat: 8'h00, cnt: 0});
      tbl.push_back('{en: 1'b0, s: 1'b1, rdy: 1'b1, vld: 1'b0, dat: 8'h00, cnt: 0});
      foreach (tbl[i]) begin
         step(tbl[i].en, tbl[i].s, tbl[i].rdy);
         chk("tbl_vld", 32'(out_valid), 32'(tbl[i].vld));
         chk("tbl_cnt", 32'(fifo_count), 32'(tbl[i].cnt));
         if (tbl[i].vld) chk("tbl_dat", 32'(out_data), 32'(tbl[i].dat));
      end

      // Overflow: five words into a four-deep FIFO, then drain.
      do_reset();
      repeat (5) send_word(8'hFF, 1'b0);
      chk("ovf_cnt", 32'(fifo_count), 32'd4);
      chk("ovf_drop", 32'(drop_count), 32'd1);
      for (int k = 0; k < 4; k++) begin
         chk("ovf_pop_vld", 32'(out_valid), 32'd1);
         chk("ovf_pop_dat", 32'(out_data), 32'hFF);
         step(1'b0, 1'b0, 1'b1);
      end
      chk("ovf_empty_vld", 32'(out_valid), 32'd0);
      chk("ovf_empty_drop", 32'(drop_count), 32'd1);

      // Full FIFO with a pop on the edge that completes a word.
      do_reset();
      send_word(8'h11, 1'b0);
      send_word(8'h22, 1'b0);
      send_word(8'h33, 1'b0);
      send_word(8'h44, 1'b0);
      send_word(8'h55, 1'b1);
      chk("fullpp_cnt", 32'(fifo_count), 32'd4);
      chk("fullpp_drop", 32'(drop_count), 32'd0);
      exp_q = '{8'h22, 8'h33, 8'h44, 8'h55};
      foreach (exp_q[k]) begin
         chk("fullpp_dat", 32'(out_data), 32'(exp_q[k]));
         step(1'b0, 1'b0, 1'b1);
      end
      chk("fullpp_empty", 32'(out_valid), 32'd0);

      // Enable gap mid-word (and mid-pair when debiasing) is ignored.
      do_reset();
      repeat (3) send_bit(1'b1, 1'b0);
`ifdef PRNG_SAMPLER_VON_NEUMANN_EN
      step(1'b1, 1'b1, 1'b0);
      idle(5, 1'b0);
      step(1'b1, 1'b0, 1'b0);
`else
      step(1'b1, 1'b1, 1'b0);
      idle(5, 1'b0);
`endif
      repeat (4) send_bit(1'b0, 1'b0);
      chk("gap_cnt", 32'(fifo_count), 32'd1);
      chk("gap_dat", 32'(out_data), 32'hF0);

      // Reset mid-word with a word already queued.
      do_reset();
      send_word(8'hA5, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      chk("prerst_vld", 32'(out_valid), 32'd1);
      do_reset();
      send_word(8'hFF, 1'b0);
      chk("postrst_cnt", 32'(fifo_count), 32'd1);
      chk("postrst_dat", 32'(out_data), 32'hFF);

      // drop_count saturation.
      do_reset();
      for (int k = 0; k < 264; k++) begin
         w = 8'($urandom);
         send_word(w, 1'b0);
      end
      chk("sat_drop", 32'(drop_count), 32'd255);
      chk("sat_cnt", 32'(fifo_count), 32'd4);

      // Random traffic against the model.
      do_reset();
      for (int k = 0; k < 2000; k++)
         step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 2) == 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
